// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access modes, FSM states
// and the alignment rule used by the request decoder.
package dmem_pkg;

    typedef enum logic [1:0] {
        MODE_BYTE = 2'b00,
        MODE_HALF = 2'b01,
        MODE_WORD = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // A request is illegal if it uses the reserved mode or is not naturally aligned.
    function automatic logic req_is_err(input logic [1:0] mode, input logic [1:0] off);
        logic err;
        case (mode)
            MODE_BYTE: err = 1'b0;
            MODE_HALF: err = off[0];
            MODE_WORD: err = (off != 2'b00);
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_bram_be.sv
// Single-port 32-bit synchronous RAM with per-byte write enables and a
// registered read port; the array itself has no reset.
module dmem_bram_be #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [3:0]            i_be,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**DEPTH_LOG2];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (i_be[k]) begin
                r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: valid/ready request port, one-cycle
// registered response, load extension, error reporting and reset clear sweep.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2     = 8,
    parameter int ADDR_W         = DEPTH_LOG2 + 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_mode,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_busy
);

    state_e                r_state;
    state_e                w_next;
    logic [DEPTH_LOG2-1:0] r_idx;

    logic                  w_acc;
    logic                  w_err;
    logic [1:0]            w_off;
    logic [3:0]            w_lane_be;
    logic [31:0]           w_wdata_rep;

    logic [3:0]            w_ram_be;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [31:0]           w_ram_wdata;
    logic [31:0]           w_ram_rdata;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_load_ok;
    mode_e                 r_mode;
    logic [1:0]            r_off;
    logic                  r_signed;
    logic [31:0]           w_sh;
    logic [31:0]           w_ext;

    assign w_off = req_addr[1:0];
    assign w_err = req_is_err(req_mode, w_off);
    assign w_acc = req_valid & req_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_INIT) begin
                r_idx <= r_idx + DEPTH_LOG2'(1);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        init_busy = 1'b0;
        case (r_state)
            ST_INIT: begin
                init_busy = CLEAR_ON_RESET;
                if (!CLEAR_ON_RESET || r_idx == '1) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                req_ready = 1'b1;
            end
        endcase
    end

    // Stores land in the addressed lanes; the data is replicated so every lane sees it.
    always_comb begin
        w_lane_be   = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_mode)
            MODE_BYTE: begin
                w_lane_be   = 4'b0001 << w_off;
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            MODE_HALF: begin
                w_lane_be   = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            MODE_WORD: w_lane_be = 4'b1111;
            default:   w_lane_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_ram_be    = '0;
        w_ram_addr  = req_addr[ADDR_W-1:2];
        w_ram_wdata = w_wdata_rep;
        if (r_state == ST_INIT) begin
            w_ram_addr  = r_idx;
            w_ram_wdata = '0;
            w_ram_be    = CLEAR_ON_RESET ? 4'b1111 : 4'b0000;
        end else if (w_acc && req_we && !w_err) begin
            w_ram_be = w_lane_be;
        end
    end

    dmem_bram_be #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bram (
        .clk    (clk),
        .i_be   (w_ram_be),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_load_ok   <= 1'b0;
            r_mode      <= MODE_BYTE;
            r_off       <= '0;
            r_signed    <= 1'b0;
        end else begin
            r_rsp_valid <= w_acc;
            r_rsp_err   <= w_acc & w_err;
            r_load_ok   <= w_acc & ~req_we & ~w_err;
            if (w_acc) begin
                r_mode   <= mode_e'(req_mode);
                r_off    <= w_off;
                r_signed <= req_signed;
            end
        end
    end

    // Aligned halves have off[0]=0, so one byte-granular shift serves both lane sizes.
    assign w_sh = w_ram_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_ram_rdata;
        case (r_mode)
            MODE_BYTE: w_ext = {{24{r_signed & w_sh[7]}}, w_sh[7:0]};
            MODE_HALF: w_ext = {{16{r_signed & w_sh[15]}}, w_sh[15:0]};
            default:   w_ext = w_ram_rdata;
        endcase
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_load_ok ? w_ext : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed test-plan scenarios plus
// randomized traffic checked against a byte-addressed memory model.
module tb_dmem_ctrl;

    localparam int DL2 = 4;
    localparam int DEP = 2**DL2;
    localparam int AW  = DL2 + 2;

    logic          clk = 1'b0;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_mode;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m [DEP];

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DEPTH_LOG2    (DL2),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_mode  (req_mode),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_busy (init_busy)
    );

    // Reference: memory is a flat array of bytes; an access touches `size`
    // consecutive bytes starting at the byte address.
    function automatic void model(input logic we, input logic [1:0] mode, input logic sgn,
                                  input logic [AW-1:0] addr, input logic [31:0] wd,
                                  output logic [31:0] erd, output logic eerr);
        int unsigned size;
        int unsigned idx;
        int unsigned base;
        size = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : 4;
        eerr = (mode == 2'd3) || (int'(addr) % size != 0);
        erd  = '0;
        if (eerr) return;
        idx  = int'(addr) / 4;
        base = int'(addr) % 4;
        for (int unsigned b = 0; b < size; b++) begin
            if (we) m[idx][8*(base+b) +: 8] = wd[8*b +: 8];
            else    erd[8*b +: 8] = m[idx][8*(base+b) +: 8];
        end
        if (!we && sgn && size < 4 && erd[8*size-1]) erd = erd | (32'hFFFF_FFFF << (8*size));
    endfunction

    task automatic issue(input logic we, input logic [1:0] mode, input logic sgn,
                         input logic [AW-1:0] addr, input logic [31:0] wd,
                         output logic ov, output logic [31:0] ord, output logic oerr);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_mode   = mode;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        ov   = rsp_valid;
        ord  = rsp_rdata;
        oerr = rsp_err;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        logic ov, oe;
        logic [31:0] od, erd;
        logic eerr;
        clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_mode = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || init_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b busy=%b, want 0 0 0 0 1",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy);
        end
        @(negedge clk);
        clr = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_tests++;
        if (cnt !== DEP || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_len: busy cycles=%0d ready=%b, want %0d 1", cnt, req_ready, DEP);
        end
        foreach (m[i]) m[i] = '0;
        model(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, erd, eerr);
        issue(1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, ov, od, oe);
        idle();
        n_tests++;
        if (ov !== 1'b1 || od !== erd || oe !== eerr || od !== 32'h0) begin
            n_fail++;
            $display("FAIL cleared_load: valid=%b rdata=%h err=%b, want 1 00000000 0", ov, od, oe);
        end
    endtask

    task automatic test_load_ext();
        logic [AW-1:0] ta [5] = '{6'h10, 6'h13, 6'h13, 6'h12, 6'h10};
        logic [1:0]    tm [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        logic          ts [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0]   te [5] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                                  32'hFFFF_80FF, 32'h0000_7F01};
        logic ov, oe, eerr;
        logic [31:0] od, erd;
        model(1'b1, 2'd2, 1'b0, 6'h10, 32'h80FF_7F01, erd, eerr);
        issue(1'b1, 2'd2, 1'b0, 6'h10, 32'h80FF_7F01, ov, od, oe);
        n_tests++;
        if (ov !== 1'b1 || od !== 32'h0 || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL store_rsp: valid=%b rdata=%h err=%b, want 1 00000000 0", ov, od, oe);
        end
        for (int i = 0; i < 5; i++) begin
            model(1'b0, tm[i], ts[i], ta[i], 32'h0, erd, eerr);
            issue(1'b0, tm[i], ts[i], ta[i], 32'h0, ov, od, oe);
            n_tests++;
            if (ov !== 1'b1 || od !== te[i] || oe !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ext[%0d]: valid=%b rdata=%h err=%b, want 1 %h 0", i, ov, od, oe, te[i]);
            end
        end
        idle();
    endtask

    task automatic test_partial();
        logic ov, oe, eerr;
        logic [31:0] od, erd;
        model(1'b1, 2'd2, 1'b0, 6'h20, 32'h0, erd, eerr);
        issue(1'b1, 2'd2, 1'b0, 6'h20, 32'h0, ov, od, oe);
        model(1'b1, 2'd0, 1'b0, 6'h21, 32'h0000_00AB, erd, eerr);
        issue(1'b1, 2'd0, 1'b0, 6'h21, 32'h0000_00AB, ov, od, oe);
        model(1'b1, 2'd1, 1'b0, 6'h22, 32'h0000_1234, erd, eerr);
        issue(1'b1, 2'd1, 1'b0, 6'h22, 32'h0000_1234, ov, od, oe);
        model(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, erd, eerr);
        issue(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, ov, od, oe);
        idle();
        n_tests++;
        if (ov !== 1'b1 || od !== 32'h1234_AB00 || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_store: valid=%b rdata=%h err=%b, want 1 1234ab00 0", ov, od, oe);
        end
    endtask

    task automatic test_errors();
        logic          tw [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]    tm [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [AW-1:0] ta [4] = '{6'h21, 6'h23, 6'h20, 6'h22};
        logic ov, oe, eerr;
        logic [31:0] od, erd;
        for (int i = 0; i < 4; i++) begin
            model(tw[i], tm[i], 1'b1, ta[i], 32'h5555_5555, erd, eerr);
            issue(tw[i], tm[i], 1'b1, ta[i], 32'h5555_5555, ov, od, oe);
            n_tests++;
            if (ov !== 1'b1 || od !== 32'h0 || oe !== 1'b1) begin
                n_fail++;
                $display("FAIL err[%0d]: valid=%b rdata=%h err=%b, want 1 00000000 1", i, ov, od, oe);
            end
        end
        model(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, erd, eerr);
        issue(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, ov, od, oe);
        idle();
        n_tests++;
        if (ov !== 1'b1 || od !== 32'h1234_AB00 || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL err_store_nowrite: rdata=%h err=%b, want 1234ab00 0", od, oe);
        end
    endtask

    task automatic test_back_to_back();
        logic ov, oe, eerr, we, sg;
        logic [1:0] md;
        logic [AW-1:0] ad;
        logic [31:0] od, erd, wd;
        for (int i = 0; i < 8; i++) begin
            we = (i % 2 == 0);
            md = 2'($urandom_range(0, 2));
            sg = 1'($urandom);
            ad = AW'($urandom) & ~AW'(md == 2'd0 ? 0 : md == 2'd1 ? 1 : 3);
            wd = $urandom;
            model(we, md, sg, ad, wd, erd, eerr);
            issue(we, md, sg, ad, wd, ov, od, oe);
            n_tests++;
            if (ov !== 1'b1 || od !== erd || oe !== eerr) begin
                n_fail++;
                $display("FAIL b2b[%0d]: valid=%b rdata=%h err=%b, want 1 %h %b", i, ov, od, oe, erd, eerr);
            end
        end
        idle();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tail: rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_random();
        logic ov, oe, eerr, we, sg;
        logic [1:0] md;
        logic [AW-1:0] ad;
        logic [31:0] od, erd, wd;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                n_tests++;
                if (rsp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_idle[%0d]: rsp_valid=%b, want 0", i, rsp_valid);
                end
            end else begin
                we = 1'($urandom);
                md = 2'($urandom);
                sg = 1'($urandom);
                ad = AW'($urandom);
                wd = $urandom;
                model(we, md, sg, ad, wd, erd, eerr);
                issue(we, md, sg, ad, wd, ov, od, oe);
                n_tests++;
                if (ov !== 1'b1 || od !== erd || oe !== eerr) begin
                    n_fail++;
                    $display("FAIL rnd[%0d] we=%b mode=%0d addr=%h: valid=%b rdata=%h err=%b, want 1 %h %b",
                             i, we, md, ad, ov, od, oe, erd, eerr);
                end
            end
        end
        idle();
    endtask

    task automatic test_midclr();
        int cnt;
        logic ov, oe, eerr;
        logic [31:0] od, erd;
        model(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, erd, eerr);
        issue(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, ov, od, oe);
        clr = 1'b1;
        req_valid = 1'b0;
        #1;
        n_tests++;
        if (ov !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_drop: prior valid=%b now valid=%b rdata=%h ready=%b, want 1 0 0 0",
                     ov, rsp_valid, rsp_rdata, req_ready);
        end
        @(negedge clk);
        clr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        n_tests++;
        if (init_busy !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_midsweep: busy=%b ready=%b, want 1 0", init_busy, req_ready);
        end
        @(negedge clk);
        clr = 1'b0;
        cnt = 0;
        while (init_busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        n_tests++;
        if (cnt !== DEP || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL resweep_len: busy cycles=%0d ready=%b, want %0d 1", cnt, req_ready, DEP);
        end
        foreach (m[i]) m[i] = '0;
        model(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, erd, eerr);
        issue(1'b0, 2'd2, 1'b0, 6'h20, 32'h0, ov, od, oe);
        idle();
        n_tests++;
        if (ov !== 1'b1 || od !== erd || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL resweep_clear: valid=%b rdata=%h err=%b, want 1 %h 0", ov, od, oe, erd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_ext();
        test_partial();
        test_errors();
        test_back_to_back();
        test_random();
        test_midclr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
